// File: rtl/trail_writer_multi_if.sv
// Frame-buffer write port and sprite ROM read port of the trail writer.
// The master side (the writer) drives addresses, data and write valid.
interface trail_writer_multi_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int ROM_AW = 6
) ();
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_we;
  logic              fb_ready;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output fb_addr, fb_data, fb_we, rom_addr,
    input  fb_ready, rom_data
  );

  modport slave (
    input  fb_addr, fb_data, fb_we, rom_addr,
    output fb_ready, rom_data
  );
endinterface

// File: rtl/trail_writer_multi.sv
// Multi-player trail writer: detects cell changes, queues one request per player,
// arbitrates round-robin and copies the matching sprite from ROM into the frame buffer.
module trail_writer_multi #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         COORD_W     = 8,
  parameter int         ADDR_W      = 20,
  parameter int         DATA_W      = 16,
  parameter int         ROW_STRIDE  = 320,
  parameter int         CELL_W      = 2,
  parameter int         CELL_H      = 4,
  parameter int         X_OFF       = 0,
  parameter int         Y_OFF       = 0,
  parameter logic [2:0] RUN_STATE   = 3'b010
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [2:0]                     Game_State,
  input  logic [NUM_PLAYERS*COORD_W-1:0] Pos_X,
  input  logic [NUM_PLAYERS*COORD_W-1:0] Pos_Y,
  input  logic [NUM_PLAYERS*2-1:0]       Dir,
  trail_writer_multi_if.master           mem,
  output logic                           busy,
  output logic [NUM_PLAYERS-1:0]         drop
);

  localparam int ROM_AW = $clog2(NUM_PLAYERS*3*CELL_W*CELL_H);
  localparam int PW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int PW1    = PW + 1;
  localparam int RW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int CW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SLOT_W = 2 + 2*COORD_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WAIT, S_WRITE} state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_ptr;
  logic [PW-1:0]             r_cur_p;
  logic [1:0]                r_cur_type;
  logic [COORD_W-1:0]        r_cur_x;
  logic [COORD_W-1:0]        r_cur_y;
  logic [ADDR_W-1:0]         r_row_addr;
  logic [RW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic [ROM_AW-1:0]         r_rom_addr;
  logic [ADDR_W-1:0]         r_fb_addr;
  logic [DATA_W-1:0]         r_fb_data;
  logic                      r_fb_we;

  logic                      w_run;
  logic [NUM_PLAYERS-1:0]    w_pend;
  logic [NUM_PLAYERS-1:0]    w_gnt_hit;
  logic [NUM_PLAYERS*SLOT_W-1:0] w_slot_flat;
  logic [NUM_PLAYERS-1:0]    w_rot;
  logic [PW-1:0]             w_off;
  logic [PW1-1:0]            w_sum;
  logic [PW-1:0]             w_gnt_idx;
  logic [PW1-1:0]            w_ptr_inc;
  logic [PW-1:0]             w_ptr_next;
  logic                      w_gnt_valid;
  logic                      w_gnt_fire;
  logic [SLOT_W-1:0]         w_gnt_slot;
  logic [ADDR_W-1:0]         w_bx;
  logic [ADDR_W-1:0]         w_by;
  logic [ADDR_W-1:0]         w_base;
  logic [ROM_AW-1:0]         w_rom_start;

  assign w_run = (Game_State == RUN_STATE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [COORD_W-1:0] w_x, w_y;
      logic [1:0]         w_dir, w_type;
      logic               w_move;
      logic [COORD_W-1:0] r_x_old, r_y_old, r_slot_x, r_slot_y;
      logic [1:0]         r_dir_old, r_slot_type;
      logic               r_pend, r_drop;

      assign w_x    = Pos_X[gi*COORD_W +: COORD_W];
      assign w_y    = Pos_Y[gi*COORD_W +: COORD_W];
      assign w_dir  = Dir[gi*2 +: 2];
      assign w_move = w_run && ((w_x != r_x_old) || (w_y != r_y_old));
      assign w_type = (w_dir != r_dir_old) ? 2'd2 : (w_dir[1] ? 2'd0 : 2'd1);

      assign w_pend[gi]    = r_pend;
      assign drop[gi]      = r_drop;
      assign w_gnt_hit[gi] = w_gnt_fire && (w_gnt_idx == PW'(gi));
      assign w_slot_flat[gi*SLOT_W +: SLOT_W] = {r_slot_type, r_slot_x, r_slot_y};

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_x_old     <= '0;
          r_y_old     <= '0;
          r_dir_old   <= '0;
          r_slot_x    <= '0;
          r_slot_y    <= '0;
          r_slot_type <= '0;
          r_pend      <= 1'b0;
          r_drop      <= 1'b0;
        end else begin
          r_x_old   <= w_x;
          r_y_old   <= w_y;
          r_dir_old <= w_dir;
          if (!w_run) begin
            r_pend <= 1'b0;
            r_drop <= 1'b0;
          end else if (w_move) begin
            // A grant in this cycle reads the old slot contents before they are replaced.
            r_slot_type <= w_type;
            r_slot_x    <= w_x;
            r_slot_y    <= w_y;
            r_pend      <= 1'b1;
            if (r_pend && !w_gnt_hit[gi]) r_drop <= 1'b1;
          end else if (w_gnt_hit[gi]) begin
            r_pend <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Rotate pending so that bit 0 is the player at the pointer, then take the lowest set bit.
  assign w_rot = NUM_PLAYERS'({w_pend, w_pend} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int k = NUM_PLAYERS-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
  end

  assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt_idx   = (w_sum >= PW1'(NUM_PLAYERS)) ? PW'(w_sum - PW1'(NUM_PLAYERS)) : PW'(w_sum);
  assign w_ptr_inc   = {1'b0, w_gnt_idx} + PW1'(1);
  assign w_ptr_next  = (w_ptr_inc >= PW1'(NUM_PLAYERS)) ? '0 : PW'(w_ptr_inc);
  assign w_gnt_valid = |w_pend;
  assign w_gnt_fire  = w_run && (r_state == S_IDLE) && w_gnt_valid;
  assign w_gnt_slot  = w_slot_flat[w_gnt_idx*SLOT_W +: SLOT_W];

  assign w_bx        = ADDR_W'(r_cur_x) + ADDR_W'(X_OFF);
  assign w_by        = ADDR_W'(r_cur_y) + ADDR_W'(Y_OFF);
  assign w_base      = w_bx * ADDR_W'(CELL_W) + w_by * ADDR_W'(CELL_H*ROW_STRIDE);
  // Sprite words are stored row-major, so the ROM address simply counts up from here.
  assign w_rom_start = ROM_AW'((int'(r_cur_p)*3 + int'(r_cur_type)) * (CELL_W*CELL_H));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cur_p    <= '0;
      r_cur_type <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_row_addr <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_rom_addr <= '0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_fb_we    <= 1'b0;
    end else if (!w_run) begin
      r_state <= S_IDLE;
      r_fb_we <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_cur_p                     <= w_gnt_idx;
            {r_cur_type, r_cur_x, r_cur_y} <= w_gnt_slot;
            r_ptr                       <= w_ptr_next;
            r_state                     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_row_addr <= w_base;
          r_row      <= '0;
          r_col      <= '0;
          r_rom_addr <= w_rom_start;
          r_state    <= S_READ;
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_fb_data <= mem.rom_data;
          r_fb_addr <= r_row_addr + ADDR_W'(r_col);
          r_fb_we   <= 1'b1;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          if (mem.fb_ready) begin
            r_fb_we    <= 1'b0;
            r_rom_addr <= r_rom_addr + ROM_AW'(1);
            if (r_col == CW'(CELL_W-1)) begin
              r_col      <= '0;
              r_row_addr <= r_row_addr + ADDR_W'(ROW_STRIDE);
              if (r_row == RW'(CELL_H-1)) begin
                r_state <= S_IDLE;
              end else begin
                r_row   <= r_row + RW'(1);
                r_state <= S_READ;
              end
            end else begin
              r_col   <= r_col + CW'(1);
              r_state <= S_READ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.fb_addr  = r_fb_addr;
  assign mem.fb_data  = r_fb_data;
  assign mem.fb_we    = r_fb_we;
  assign mem.rom_addr = r_rom_addr;
  assign busy         = (r_state != S_IDLE);

endmodule
